reg7_down_counter: RTL and testbench

- Synchronous 7-bit binary down counter built by the synchronous-design method: a chain of T flip-flops sharing one clock.
- Each stage toggles when enable is high and every lower stage is 0 (borrow chain of AND gates).
- Used as a general-purpose countdown/timer register; provides its count and a terminal-count flag.

---
 rtl/reg7_down_counter_pkg.sv | 6 +
 rtl/reg7_down_counter_tff_cell.sv | 16 +
 rtl/reg7_down_counter.sv | 47 ++++
 tb/tb_reg7_down_counter.sv | 108 ++++++++++
 4 files changed

// File: rtl/reg7_down_counter_pkg.sv
// Shared constants and types for the 7-bit synchronous down counter.
package reg7_down_counter_pkg;
    localparam int CNT_WIDTH = 7;
    localparam logic [CNT_WIDTH-1:0] CNT_RESET_VAL = 7'h7F;
    typedef logic [CNT_WIDTH-1:0] cnt_t;
endpackage

// File: rtl/reg7_down_counter_tff_cell.sv
// Single T flip-flop stage with async active-low reset to a per-stage value.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= rst_val;
        end else if (t) begin
            q <= ~q;
        end
    end
endmodule

// File: rtl/reg7_down_counter.sv
// Synchronous down counter built from a chain of T flip-flops with an AND borrow chain.
// Optional parallel load (ports load/din) is enabled by defining DOWN_COUNTER_LOAD_EN.
module reg7_down_counter
    import reg7_down_counter_pkg::*;
#(
    parameter int               WIDTH     = CNT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
`ifdef DOWN_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] din,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             tc
);
    logic [WIDTH-1:0] zero_below;
    logic [WIDTH-1:0] t;

    // zero_below[i] is high when every bit below i is 0, i.e. bit i must borrow.
    assign zero_below[0] = 1'b1;

    for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
        assign zero_below[i] = zero_below[i-1] & ~Q[i-1];
    end

`ifdef DOWN_COUNTER_LOAD_EN
    // A load toggles exactly the bits that differ from din, so the T-FF chain stays intact.
    assign t = load ? (Q ^ din) : ({WIDTH{enable}} & zero_below);
`else
    assign t = {WIDTH{enable}} & zero_below;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        tff_cell u_tff (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RESET_VAL[i]),
            .t       (t[i]),
            .q       (Q[i])
        );
    end

    assign tc = (Q == '0);
endmodule

// File: tb/tb_reg7_down_counter.sv
// Self-checking bench for reg7_down_counter: integer reference model plus directed literal checks.
module tb_reg7_down_counter;
    import reg7_down_counter_pkg::*;

    localparam int MODV = 1 << CNT_WIDTH;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    cnt_t Q;
    logic tc;

    int checks = 0;
    int errors = 0;
    int model_q = MODV - 1;

    reg7_down_counter dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
`ifdef DOWN_COUNTER_LOAD_EN
        .load   (1'b0),
        .din    ('0),
`endif
        .Q      (Q),
        .tc     (tc)
    );

    always #5 clk = ~clk;

    // Reference: count value as a plain integer, reset forces all-ones.
    always @(posedge clk or negedge reset) begin
        if (!reset) model_q = MODV - 1;
        else if (enable) model_q = (model_q + MODV - 1) % MODV;
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_q", int'(Q), model_q);
        check("model_tc", int'(tc), (model_q == 0) ? 1 : 0);
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        enable = 1'b0;
        reset  = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("reset_async_q", int'(Q), 127);
        check("reset_async_tc", int'(tc), 0);
        @(negedge clk);
        check("reset_hold_q", int'(Q), 127);

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("hold_q", int'(Q), 127);

        enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("count_q", int'(Q), 127 - k);
        end

        #2 reset = 1'b0;
        #1;
        check("midreset_async_q", int'(Q), 127);
        repeat (2) @(negedge clk);
        check("midreset_hold_q", int'(Q), 127);

        reset = 1'b1;
        repeat (63) @(negedge clk);
        check("borrow_pre_q", int'(Q), 64);
        @(negedge clk);
        check("borrow_post_q", int'(Q), 63);

        repeat (62) @(negedge clk);
        check("near_zero_q", int'(Q), 1);
        @(negedge clk);
        check("zero_q", int'(Q), 0);
        check("zero_tc", int'(tc), 1);
        @(negedge clk);
        check("wrap_q", int'(Q), 127);
        check("wrap_tc", int'(tc), 0);

        repeat (127) @(negedge clk);
        check("zero2_q", int'(Q), 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("zero_hold_q", int'(Q), 0);
        check("zero_hold_tc", int'(tc), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
